operand_fwd_unit: RTL and testbench

//  ALU operand-B select with forwarding, next generation of the operand mux. Picks

---
 rtl/operand_fwd_unit_if.sv | 42 ++++
 rtl/operand_fwd_unit.sv | 123 ++++++++++++
 tb/tb_operand_fwd_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/operand_fwd_unit_if.sv
// Operand request / forwarding / response bundle for operand_fwd_unit.
// master = requester + producer stages + consumer side, slave = the unit.
interface operand_fwd_unit_if #(
   parameter int DATA_W    = 16,
   parameter int REG_AW    = 4,
   parameter int FWD_DEPTH = 2,
   parameter int CNT_W     = 16
);
   localparam int SW = $clog2(FWD_DEPTH + 1);

   logic                          in_valid;
   logic                          in_ready;
   logic                          alu_src;
   logic [REG_AW-1:0]             src_rs;
   logic [DATA_W-1:0]             reg_data;
   logic [DATA_W-1:0]             imm_data;
   logic [FWD_DEPTH-1:0]          fwd_wen;
   logic [FWD_DEPTH-1:0]          fwd_rdy;
   logic [FWD_DEPTH-1:0]          fwd_hi;
   logic [FWD_DEPTH*REG_AW-1:0]   fwd_rd;
   logic [FWD_DEPTH*2*DATA_W-1:0] fwd_data;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_W-1:0]             out_operand;
   logic [SW-1:0]                 out_fwd_src;
   logic                          stall;
   logic [CNT_W-1:0]              stall_cnt;
   logic                          err;
   logic                          err_clr;

   modport master (
      output in_valid, alu_src, src_rs, reg_data, imm_data,
             fwd_wen, fwd_rdy, fwd_hi, fwd_rd, fwd_data, out_ready, err_clr,
      input  in_ready, out_valid, out_operand, out_fwd_src, stall, stall_cnt, err
   );

   modport slave (
      input  in_valid, alu_src, src_rs, reg_data, imm_data,
             fwd_wen, fwd_rdy, fwd_hi, fwd_rd, fwd_data, out_ready, err_clr,
      output in_ready, out_valid, out_operand, out_fwd_src, stall, stall_cnt, err
   );
endinterface

// File: rtl/operand_fwd_unit.sv
// ALU operand-B select with youngest-producer forwarding, hazard stall,
// stall watchdog and saturating stall counter. Registered output, 1-cycle latency.
module operand_fwd_unit #(
   parameter int DATA_W    = 16,
   parameter int REG_AW    = 4,
   parameter int FWD_DEPTH = 2,
   parameter int STALL_MAX = 15,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   operand_fwd_unit_if.slave  bus
);
   localparam int SW   = $clog2(FWD_DEPTH + 1);
   localparam int WD_W = $clog2(STALL_MAX + 1);

   typedef enum logic [1:0] {S_RUN, S_STALL, S_TIMEOUT} state_t;

   state_t              r_state, w_next;
   logic [WD_W-1:0]     r_wd;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_valid;
   logic [DATA_W-1:0]   r_operand;
   logic [SW-1:0]       r_fwd_src;

   logic [FWD_DEPTH-1:0] w_match;
   logic                 w_hit;
   logic                 w_win_rdy;
   logic [SW-1:0]        w_win_src;
   logic [DATA_W-1:0]    w_fwd_val;
   logic [DATA_W-1:0]    w_operand;
   logic [SW-1:0]        w_fwd_src;
   logic                 w_hazard;
   logic                 w_stall;
   logic                 w_in_ready;
   logic                 w_capture;

   // Per-stage tag match; tag 0 and immediate selects never forward.
   for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_match
      assign w_match[k] = bus.fwd_wen[k] && !bus.alu_src && (bus.src_rs != '0) &&
                          (bus.fwd_rd[k*REG_AW +: REG_AW] == bus.src_rs);
   end

   // Youngest (lowest index) matching stage wins; iterate oldest-first so it overrides.
   always_comb begin
      w_hit     = 1'b0;
      w_win_rdy = 1'b0;
      w_win_src = '0;
      w_fwd_val = '0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (w_match[k]) begin
            w_hit     = 1'b1;
            w_win_rdy = bus.fwd_rdy[k];
            w_win_src = SW'(k + 1);
            w_fwd_val = bus.fwd_hi[k] ? bus.fwd_data[(2*k+1)*DATA_W +: DATA_W]
                                      : bus.fwd_data[(2*k)*DATA_W +: DATA_W];
         end
      end
   end

   // Operand mux; a not-ready winner stalls rather than falling back to an older stage.
   assign w_operand  = bus.alu_src ? bus.imm_data : (w_hit ? w_fwd_val : bus.reg_data);
   assign w_fwd_src  = w_hit ? w_win_src : '0;
   assign w_hazard   = bus.in_valid && w_hit && !w_win_rdy;
   assign w_stall    = w_hazard && (r_state != S_TIMEOUT);
   assign w_in_ready = (r_state != S_TIMEOUT) && !w_hazard && (!r_valid || bus.out_ready);
   assign w_capture  = bus.in_valid && w_in_ready;

   // Next-state: watchdog trips after STALL_MAX consecutive hazard cycles.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN:     if (w_hazard) w_next = S_STALL;
         S_STALL: begin
            if (!w_hazard)                          w_next = S_RUN;
            else if (r_wd == WD_W'(STALL_MAX - 1))  w_next = S_TIMEOUT;
         end
         S_TIMEOUT: if (bus.err_clr) w_next = S_RUN;
         default:   w_next = S_RUN;
      endcase
   end

   // State register and watchdog; r_wd counts hazard cycles of the current stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_wd    <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_STALL) r_wd <= (r_state == S_STALL) ? r_wd + 1'b1 : WD_W'(1);
         else                   r_wd <= '0;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_cnt <= '0;
      else if (w_stall && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
   end

   // Output register: load on capture, hold under backpressure, drain on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_operand <= '0;
         r_fwd_src <= '0;
      end else if (w_capture) begin
         r_valid   <= 1'b1;
         r_operand <= w_operand;
         r_fwd_src <= w_fwd_src;
      end else if (bus.out_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_valid;
   assign bus.out_operand = r_operand;
   assign bus.out_fwd_src = r_fwd_src;
   assign bus.stall       = w_stall;
   assign bus.stall_cnt   = r_cnt;
   assign bus.err         = (r_state == S_TIMEOUT);
endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed bench for operand_fwd_unit: immediate/forward/register select,
// hazard stall, watchdog timeout, backpressure and async reset.
module tb_operand_fwd_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   operand_fwd_unit_if #(.DATA_W(16), .REG_AW(4), .FWD_DEPTH(2), .CNT_W(16)) bus ();

   operand_fwd_unit #(.DATA_W(16), .REG_AW(4), .FWD_DEPTH(2), .STALL_MAX(15), .CNT_W(16))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.alu_src  = 1'b0;
      bus.src_rs   = '0;
      bus.reg_data = '0;
      bus.imm_data = '0;
      bus.fwd_wen  = '0;
      bus.fwd_rdy  = '0;
      bus.fwd_hi   = '0;
      bus.fwd_rd   = '0;
      bus.fwd_data = '0;
      bus.out_ready = 1'b1;
      bus.err_clr  = 1'b0;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_operand",   32'(bus.out_operand), 32'd0);
      chk("rst_fwd_src",   32'(bus.out_fwd_src), 32'd0);
      chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("rst_err",       32'(bus.err), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // T1: immediate wins even with matching not-ready producers
      bus.in_valid = 1'b1;
      bus.alu_src  = 1'b1;
      bus.imm_data = 16'hFFF0;
      bus.src_rs   = 4'd3;
      bus.fwd_wen  = 2'b11;
      bus.fwd_rd   = {4'd3, 4'd3};
      bus.fwd_rdy  = 2'b00;
      #1;
      chk("t1_stall",    32'(bus.stall), 32'd0);
      chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      chk("t1_valid",   32'(bus.out_valid), 32'd1);
      chk("t1_operand", 32'(bus.out_operand), 32'hFFF0);
      chk("t1_src",     32'(bus.out_fwd_src), 32'd0);

      // T2: youngest stage wins, lo half
      bus.alu_src  = 1'b0;
      bus.fwd_rdy  = 2'b11;
      bus.fwd_hi   = 2'b00;
      bus.fwd_data = {32'hDEAD_BEEF, 32'h1234_ABCD};
      step();
      chk("t2_operand", 32'(bus.out_operand), 32'hABCD);
      chk("t2_src",     32'(bus.out_fwd_src), 32'd1);

      // T3: only stage1 matches, hi half; then tag 0 never forwards
      bus.src_rs   = 4'd5;
      bus.fwd_wen  = 2'b10;
      bus.fwd_rd   = {4'd5, 4'd2};
      bus.fwd_hi   = 2'b10;
      bus.fwd_data = {32'h5A5A_0000, 32'h1111_2222};
      step();
      chk("t3_operand", 32'(bus.out_operand), 32'h5A5A);
      chk("t3_src",     32'(bus.out_fwd_src), 32'd2);
      bus.src_rs   = 4'd0;
      bus.fwd_wen  = 2'b11;
      bus.fwd_rd   = {4'd0, 4'd0};
      bus.reg_data = 16'h7777;
      step();
      chk("t3_rs0_operand", 32'(bus.out_operand), 32'h7777);
      chk("t3_rs0_src",     32'(bus.out_fwd_src), 32'd0);

      // T4: stage0 not ready for 3 cycles (stage1 ready is ignored)
      bus.src_rs   = 4'd4;
      bus.fwd_wen  = 2'b11;
      bus.fwd_rd   = {4'd4, 4'd4};
      bus.fwd_rdy  = 2'b10;
      bus.fwd_hi   = 2'b00;
      bus.fwd_data = {32'h0000_9999, 32'h0000_4444};
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_stall",    32'(bus.stall), 32'd1);
         chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
         step();
      end
      chk("t4_drained", 32'(bus.out_valid), 32'd0);
      bus.fwd_rdy = 2'b11;
      #1;
      chk("t4_release_ready", 32'(bus.in_ready), 32'd1);
      step();
      chk("t4_operand",   32'(bus.out_operand), 32'h4444);
      chk("t4_src",       32'(bus.out_fwd_src), 32'd1);
      chk("t4_stall_cnt", 32'(bus.stall_cnt), 32'd3);

      // T5: hazard for 15 cycles trips the watchdog
      bus.src_rs  = 4'd6;
      bus.fwd_wen = 2'b01;
      bus.fwd_rd  = {4'd0, 4'd6};
      bus.fwd_rdy = 2'b00;
      for (int i = 0; i < 15; i++) begin
         #1;
         chk("t5_stall", 32'(bus.stall), 32'd1);
         chk("t5_err_pre", 32'(bus.err), 32'd0);
         step();
      end
      chk("t5_err",       32'(bus.err), 32'd1);
      chk("t5_in_ready",  32'(bus.in_ready), 32'd0);
      chk("t5_stall_off", 32'(bus.stall), 32'd0);
      chk("t5_stall_cnt", 32'(bus.stall_cnt), 32'd18);
      step();
      chk("t5_err_sticky", 32'(bus.err), 32'd1);
      chk("t5_cnt_frozen", 32'(bus.stall_cnt), 32'd18);
      bus.in_valid = 1'b0;
      bus.err_clr  = 1'b1;
      step();
      bus.err_clr  = 1'b0;
      chk("t5_err_clr",  32'(bus.err), 32'd0);
      chk("t5_run_rdy",  32'(bus.in_ready), 32'd1);
      // in_valid drop mid-stall returns to RUN
      bus.in_valid = 1'b1;
      step();
      step();
      bus.in_valid = 1'b0;
      #1;
      chk("t5_drop_stall", 32'(bus.stall), 32'd0);
      step();
      chk("t5_drop_cnt", 32'(bus.stall_cnt), 32'd20);
      chk("t5_drop_err", 32'(bus.err), 32'd0);

      // T6: backpressure holds output and blocks capture
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.alu_src   = 1'b1;
      bus.imm_data  = 16'h00AA;
      step();
      chk("t6_valid",   32'(bus.out_valid), 32'd1);
      chk("t6_operand", 32'(bus.out_operand), 32'h00AA);
      bus.imm_data = 16'h00BB;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t6_in_ready", 32'(bus.in_ready), 32'd0);
         step();
         chk("t6_hold_op",    32'(bus.out_operand), 32'h00AA);
         chk("t6_hold_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("t6_rel_ready", 32'(bus.in_ready), 32'd1);
      step();
      chk("t6_next_op", 32'(bus.out_operand), 32'h00BB);
      // stall, then async reset mid-cycle
      bus.alu_src = 1'b0;
      bus.src_rs  = 4'd7;
      bus.fwd_rd  = {4'd0, 4'd7};
      step();
      step();
      chk("t6_stall_pre", 32'(bus.stall), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid",   32'(bus.out_valid), 32'd0);
      chk("t6_rst_operand", 32'(bus.out_operand), 32'd0);
      chk("t6_rst_src",     32'(bus.out_fwd_src), 32'd0);
      chk("t6_rst_cnt",     32'(bus.stall_cnt), 32'd0);
      chk("t6_rst_err",     32'(bus.err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
